branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning operand width in bits; legal values are 8 or more.
REQ-002 The block SHALL have parameter PC_W, default 32, meaning program-counter width in bits.
REQ-003 The block SHALL have parameter BHT_DEPTH, default 16, meaning the number of history entries; it SHALL be a power of two, 2 or more.
REQ-004 Ports SHALL be:
 - clk  in  1  rising-edge clock
 - rst_n  in  1  reset; one clock, reset asynchronous, active-low
 - pred_pc  in  PC_W  fetch-side prediction query address
 - pred_taken  out  1  combinational prediction for pred_pc
 - in_valid  in  1  resolve request valid
 - in_ready  out  1  resolve request accepted when in_valid && in_ready
 - branch_op  in  4  branch operation code
 - pc  in  PC_W  address of the branch
 - imm  in  26  immediate field; bits [15:0] are used
 - rs  in  DATA_W  first operand
 - rt  in  DATA_W  second operand
 - in_pred  in  1  prediction that fetch used for this branch
 - res_valid  out  1  result valid
 - res_ready  in  1  consumer accepts the result
 - res_taken  out  1  resolved direction
 - res_target  out  PC_W  redirect address
 - res_link_we  out  1  link write enable
 - res_link_data  out  PC_W  link value
 - res_flush  out  1  mispredict; flush younger instructions
 - mispred_cnt  out  16  saturating mispredict counter

Function
REQ-005 branch_op codes SHALL be: 0 NOT_Branch, 1 BEQ, 2 BNE, 3 BGTZ, 4 BLEZ, 5 BGEZ, 6 BLTZ, 7 BGEZAL, 8 BLTZAL; codes 9 to 15 SHALL behave as NOT_Branch.
REQ-006 Conditions SHALL be evaluated as follows, with rs and rt treated as signed DATA_W values:
 - BEQ: rs==rt
 - BNE: rs!=rt
 - BGTZ: rs>0
 - BLEZ: rs<=0
 - BGEZ and BGEZAL: rs>=0
 - BLTZ and BLTZAL: rs<0
 - NOT_Branch: 0
REQ-007 Taken target SHALL be pc+4+(sign-extended imm[15:0]<<2), computed modulo 2^PC_W.
REQ-008 res_target SHALL equal the taken target when res_taken=1, and pc+4 otherwise.
REQ-009 For BGEZAL and BLTZAL, res_link_we SHALL be 1 regardless of direction, with res_link_data=pc+8; for all other codes res_link_we=0 and res_link_data=0.
REQ-010 res_flush SHALL equal res_taken XOR captured in_pred for branch codes 1 to 8, and SHALL be 0 for NOT_Branch.
REQ-011 The result SHALL be registered: a request accepted on edge N SHALL drive res_valid=1 with its result fields after edge N, giving a latency of 1 cycle.
REQ-012 in_ready SHALL equal !res_valid || res_ready.
REQ-013 All res_* fields SHALL hold stable while res_valid && !res_ready.
REQ-014 When a new request is accepted in the same cycle that the current result is consumed, the output register SHALL reload with no bubble.
REQ-015 When the result is consumed and no new request is accepted, res_valid SHALL clear on that edge.
REQ-016 The BHT SHALL be BHT_DEPTH 2-bit saturating counters indexed by pc[log2(BHT_DEPTH)+1:2].
REQ-017 pred_taken SHALL equal bit 1 of the BHT entry for pred_pc.
REQ-018 On each accepted request with code 1 to 8, the indexed counter SHALL increment (saturating at 3) if the branch is taken, and otherwise decrement (saturating at 0).
REQ-019 NOT_Branch requests SHALL NOT modify the BHT.
REQ-020 When a query and an update target the same entry in the same cycle, pred_taken SHALL reflect the pre-update value.
REQ-021 mispred_cnt SHALL increment once per accepted request whose computed flush is 1, and SHALL saturate at 16'hFFFF.
REQ-022 Requests with in_valid=1 and in_ready=0 SHALL be ignored: no BHT update, no count; the source SHALL hold them.

Reset
REQ-023 While rst_n=0, the block SHALL force: res_valid=0; res_taken, res_target, res_link_we, res_link_data and res_flush all 0; mispred_cnt=0; every BHT entry=2'b01.
REQ-024 Assertion of rst_n in the middle of a transaction SHALL discard any pending result, and SHALL NOT emit that result after reset is released.
REQ-025 in_ready SHALL be 1 on the first cycle after reset is released.

Verification
REQ-026 A bench SHALL cover: BEQ, pc=0x100, imm=0x0004, rs=rt=5, in_pred=0 -> next cycle res_valid=1, res_taken=1, res_target=0x114, res_flush=1, mispred_cnt=1.
REQ-027 A bench SHALL cover: BLTZAL, pc=0x200, rs=1, in_pred=0 -> res_taken=0, res_target=0x204, res_link_we=1, res_link_data=0x208, res_flush=0.
REQ-028 A bench SHALL cover: BGTZ, rs=0x80000000, imm=0xFFFF, pc=0x40 -> res_taken=0; then the same request with rs=1 -> res_taken=1, res_target=0x40.
REQ-029 A bench SHALL cover: three taken BNE at pc=0x10 -> entry 4 goes 01 to 10 to 11 to 11, and pred_taken for pred_pc=0x10 is 1 after the first update.
REQ-030 A bench SHALL cover: res_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, BHT and mispred_cnt unchanged; on raising res_ready, a back-to-back reload occurs.
REQ-031 A bench SHALL cover: rst_n pulsed low while res_valid=1 -> res_valid=0 immediately, all BHT entries read 01, and mispred_cnt=0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates branch conditions, produces a registered redirect/link
// result behind a valid/ready handshake, and trains a 2-bit bimodal history table.
module branch_resolve_unit #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_taken,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        branch_op,
    input  logic [PC_W-1:0]   pc,
    input  logic [25:0]       imm,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    input  logic              in_pred,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [PC_W-1:0]   res_target,
    output logic              res_link_we,
    output logic [PC_W-1:0]   res_link_data,
    output logic              res_flush,
    output logic [15:0]       mispred_cnt
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [3:0] OP_BEQ    = 4'd1;
    localparam logic [3:0] OP_BNE    = 4'd2;
    localparam logic [3:0] OP_BGTZ   = 4'd3;
    localparam logic [3:0] OP_BLEZ   = 4'd4;
    localparam logic [3:0] OP_BGEZ   = 4'd5;
    localparam logic [3:0] OP_BLTZ   = 4'd6;
    localparam logic [3:0] OP_BGEZAL = 4'd7;
    localparam logic [3:0] OP_BLTZAL = 4'd8;

    function automatic logic [1:0] sat_ctr2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        else    return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]               r_bht [BHT_DEPTH];
    logic                     r_vld_p1;
    logic                     r_taken_p1;
    logic [PC_W-1:0]          r_target_p1;
    logic                     r_link_we_p1;
    logic [PC_W-1:0]          r_link_data_p1;
    logic                     r_flush_p1;
    logic [15:0]              r_mispred_cnt;

    logic signed [DATA_W-1:0] w_rs;
    logic signed [DATA_W-1:0] w_rt;
    logic                     w_is_br;
    logic                     w_is_link;
    logic                     w_taken;
    logic                     w_flush;
    logic                     w_accept;
    logic [PC_W-1:0]          w_pc4;
    logic [PC_W-1:0]          w_pc8;
    logic [PC_W-1:0]          w_off;
    logic [PC_W-1:0]          w_tgt;
    logic [IDX_W-1:0]         w_upd_idx;
    logic [IDX_W-1:0]         w_qry_idx;

    assign w_rs      = rs;
    assign w_rt      = rt;
    assign w_is_br   = (branch_op >= OP_BEQ) && (branch_op <= OP_BLTZAL);
    assign w_is_link = (branch_op == OP_BGEZAL) || (branch_op == OP_BLTZAL);
    assign w_pc4     = pc + PC_W'(4);
    assign w_pc8     = pc + PC_W'(8);
    assign w_off     = PC_W'($signed({imm[15:0], 2'b00}));
    assign w_tgt     = w_pc4 + w_off;
    assign w_flush   = w_is_br && (w_taken ^ in_pred);
    assign w_accept  = in_valid && in_ready;
    assign w_upd_idx = pc[IDX_W+1:2];
    assign w_qry_idx = pred_pc[IDX_W+1:2];

    always_comb begin
        w_taken = 1'b0;
        case (branch_op)
            OP_BEQ:               w_taken = (w_rs == w_rt);
            OP_BNE:               w_taken = (w_rs != w_rt);
            OP_BGTZ:              w_taken = (w_rs > 0);
            OP_BLEZ:              w_taken = (w_rs <= 0);
            OP_BGEZ, OP_BGEZAL:   w_taken = (w_rs >= 0);
            OP_BLTZ, OP_BLTZAL:   w_taken = (w_rs < 0);
            default:              w_taken = 1'b0;
        endcase
    end

    // Table is read from registered state, so a same-cycle update is not yet visible.
    assign pred_taken = r_bht[w_qry_idx][1];
    assign in_ready   = !r_vld_p1 || res_ready;

    // Stage p0 -> p1: result register, history training and mispredict counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1       <= 1'b0;
            r_taken_p1     <= 1'b0;
            r_target_p1    <= '0;
            r_link_we_p1   <= 1'b0;
            r_link_data_p1 <= '0;
            r_flush_p1     <= 1'b0;
            r_mispred_cnt  <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
        end else begin
            if (w_accept) begin
                r_vld_p1       <= 1'b1;
                r_taken_p1     <= w_taken;
                r_target_p1    <= w_taken ? w_tgt : w_pc4;
                r_link_we_p1   <= w_is_link;
                r_link_data_p1 <= w_is_link ? w_pc8 : '0;
                r_flush_p1     <= w_flush;
            end else if (res_ready) begin
                r_vld_p1 <= 1'b0;
            end
            if (w_accept && w_is_br) r_bht[w_upd_idx] <= sat_ctr2(r_bht[w_upd_idx], w_taken);
            if (w_accept && w_flush) r_mispred_cnt <= sat_inc16(r_mispred_cnt);
        end
    end

    assign res_valid     = r_vld_p1;
    assign res_taken     = r_taken_p1;
    assign res_target    = r_target_p1;
    assign res_link_we   = r_link_we_p1;
    assign res_link_data = r_link_data_p1;
    assign res_flush     = r_flush_p1;
    assign mispred_cnt   = r_mispred_cnt;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit with hand-computed expected results.
module tb_branch_resolve_unit;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;

    logic              clk;
    logic              rst_n;
    logic [PC_W-1:0]   pred_pc;
    logic              pred_taken;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        branch_op;
    logic [PC_W-1:0]   pc;
    logic [25:0]       imm;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic              in_pred;
    logic              res_valid;
    logic              res_ready;
    logic              res_taken;
    logic [PC_W-1:0]   res_target;
    logic              res_link_we;
    logic [PC_W-1:0]   res_link_data;
    logic              res_flush;
    logic [15:0]       mispred_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolve_unit #(.DATA_W(DATA_W), .PC_W(PC_W), .BHT_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .in_valid(in_valid), .in_ready(in_ready), .branch_op(branch_op), .pc(pc),
        .imm(imm), .rs(rs), .rt(rt), .in_pred(in_pred), .res_valid(res_valid),
        .res_ready(res_ready), .res_taken(res_taken), .res_target(res_target),
        .res_link_we(res_link_we), .res_link_data(res_link_data),
        .res_flush(res_flush), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] pcv, input logic [25:0] immv,
                         input logic [31:0] rsv, input logic [31:0] rtv, input logic pr);
        branch_op = op;
        pc        = pcv;
        imm       = immv;
        rs        = rsv;
        rt        = rtv;
        in_pred   = pr;
        in_valid  = 1'b1;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] pcv, input logic [25:0] immv,
                        input logic [31:0] rsv, input logic [31:0] rtv, input logic pr);
        drive(op, pcv, immv, rsv, rtv, pr);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic tk, input logic [31:0] tgt,
                           input logic lwe, input logic [31:0] ldat, input logic fl,
                           input logic [15:0] mis);
        chk({tag, ".valid"},  64'(res_valid), 64'(1'b1));
        chk({tag, ".taken"},  64'(res_taken), 64'(tk));
        chk({tag, ".target"}, 64'(res_target), 64'(tgt));
        chk({tag, ".lwe"},    64'(res_link_we), 64'(lwe));
        chk({tag, ".ldata"},  64'(res_link_data), 64'(ldat));
        chk({tag, ".flush"},  64'(res_flush), 64'(fl));
        chk({tag, ".mis"},    64'(mispred_cnt), 64'(mis));
    endtask

    initial begin
        rst_n = 1'b0; pred_pc = '0; in_valid = 1'b0; branch_op = '0; pc = '0;
        imm = '0; rs = '0; rt = '0; in_pred = 1'b0; res_ready = 1'b1;
        repeat (2) tick();
        chk("rst.valid",  64'(res_valid), 64'd0);
        chk("rst.target", 64'(res_target), 64'd0);
        chk("rst.ldata",  64'(res_link_data), 64'd0);
        chk("rst.mis",    64'(mispred_cnt), 64'd0);
        #2 rst_n = 1'b1;
        #1 chk("rel.in_ready", 64'(in_ready), 64'd1);

        send(4'd1, 32'h100, 26'h0004, 32'd5, 32'd5, 1'b0);
        chk_res("beq", 1'b1, 32'h114, 1'b0, 32'h0, 1'b1, 16'd1);
        send(4'd8, 32'h200, 26'h0004, 32'd1, 32'd0, 1'b0);
        chk_res("bltzal", 1'b0, 32'h204, 1'b1, 32'h208, 1'b0, 16'd1);
        send(4'd3, 32'h40, 26'hFFFF, 32'h8000_0000, 32'd0, 1'b0);
        chk_res("bgtz.neg", 1'b0, 32'h44, 1'b0, 32'h0, 1'b0, 16'd1);
        send(4'd3, 32'h40, 26'hFFFF, 32'd1, 32'd0, 1'b0);
        chk_res("bgtz.pos", 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 16'd2);
        send(4'd4, 32'h300, 26'h0002, 32'd0, 32'd0, 1'b1);
        chk_res("blez", 1'b1, 32'h30C, 1'b0, 32'h0, 1'b0, 16'd2);
        send(4'd5, 32'h300, 26'h0002, 32'hFFFF_FFFF, 32'd0, 1'b0);
        chk_res("bgez", 1'b0, 32'h304, 1'b0, 32'h0, 1'b0, 16'd2);
        send(4'd6, 32'h300, 26'h0002, 32'hFFFF_FFFF, 32'd0, 1'b1);
        chk_res("bltz", 1'b1, 32'h30C, 1'b0, 32'h0, 1'b0, 16'd2);
        send(4'd7, 32'h300, 26'h0002, 32'd0, 32'd0, 1'b0);
        chk_res("bgezal", 1'b1, 32'h30C, 1'b1, 32'h308, 1'b1, 16'd3);
        send(4'd0, 32'h300, 26'h0002, 32'd0, 32'd0, 1'b1);
        chk_res("nobr", 1'b0, 32'h304, 1'b0, 32'h0, 1'b0, 16'd3);
        send(4'd12, 32'h300, 26'h0002, 32'd3, 32'd3, 1'b1);
        chk_res("op12", 1'b0, 32'h304, 1'b0, 32'h0, 1'b0, 16'd3);
        tick();
        chk("drain.valid", 64'(res_valid), 64'd0);

        // History training at pc=0x10 (entry 4)
        pred_pc = 32'h10;
        #1 chk("bht4.init", 64'(pred_taken), 64'd0);
        drive(4'd2, 32'h10, 26'h0000, 32'd1, 32'd2, 1'b0);
        #1 chk("bht4.pre_upd", 64'(pred_taken), 64'd0);
        tick(); in_valid = 1'b0;
        chk_res("bne1", 1'b1, 32'h14, 1'b0, 32'h0, 1'b1, 16'd4);
        chk("bht4.after1", 64'(pred_taken), 64'd1);
        send(4'd2, 32'h10, 26'h0000, 32'd1, 32'd2, 1'b1);
        chk("bne2.flush", 64'(res_flush), 64'd0);
        send(4'd2, 32'h10, 26'h0000, 32'd1, 32'd2, 1'b1);
        chk("bht4.after3", 64'(pred_taken), 64'd1);
        send(4'd2, 32'h10, 26'h0000, 32'd2, 32'd2, 1'b1);
        chk_res("bne.nt1", 1'b0, 32'h14, 1'b0, 32'h0, 1'b1, 16'd5);
        chk("bht4.sat_dec1", 64'(pred_taken), 64'd1);
        send(4'd2, 32'h10, 26'h0000, 32'd2, 32'd2, 1'b0);
        chk("bht4.sat_dec2", 64'(pred_taken), 64'd0);
        tick();

        // Backpressure: result A stalls while request B waits
        res_ready = 1'b0;
        send(4'd1, 32'h500, 26'h0010, 32'd7, 32'd7, 1'b0);
        chk_res("bpA", 1'b1, 32'h544, 1'b0, 32'h0, 1'b1, 16'd6);
        drive(4'd2, 32'h14, 26'h0001, 32'd1, 32'd2, 1'b0);
        pred_pc = 32'h14;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp.in_ready", 64'(in_ready), 64'd0);
            chk("bp.target",   64'(res_target), 64'h544);
            chk("bp.valid",    64'(res_valid), 64'd1);
            chk("bp.mis",      64'(mispred_cnt), 64'd6);
            chk("bp.bht5",     64'(pred_taken), 64'd0);
        end
        res_ready = 1'b1;
        #1 chk("bp.in_ready_up", 64'(in_ready), 64'd1);
        tick(); in_valid = 1'b0;
        chk_res("bpB", 1'b1, 32'h1C, 1'b0, 32'h0, 1'b1, 16'd7);
        chk("bp.bht5_upd", 64'(pred_taken), 64'd1);
        tick();
        chk("bp.clear", 64'(res_valid), 64'd0);

        // Reset in the middle of a stalled result
        res_ready = 1'b0;
        send(4'd1, 32'h600, 26'h0000, 32'd9, 32'd9, 1'b0);
        chk("mid.valid", 64'(res_valid), 64'd1);
        chk("mid.mis",   64'(mispred_cnt), 64'd8);
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 64'(res_valid), 64'd0);
        chk("arst.mis",   64'(mispred_cnt), 64'd0);
        chk("arst.taken", 64'(res_taken), 64'd0);
        tick();
        #2 rst_n = 1'b1;
        res_ready = 1'b1;
        tick();
        chk("post.valid", 64'(res_valid), 64'd0);
        chk("post.in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 16; i++) begin
            pred_pc = 32'(i * 4);
            #1 chk($sformatf("bht%0d.rst", i), 64'(pred_taken), 64'd0);
            send(4'd2, 32'(i * 4), 26'h0000, 32'd1, 32'd2, 1'b1);
            chk($sformatf("bht%0d.one_up", i), 64'(pred_taken), 64'd1);
        end
        chk("post.mis", 64'(mispred_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
